// File: rtl/pkt_pkg.sv
// Shared types and defaults for the packet ingress arbiter.
package pkt_pkg;

  localparam int unsigned DEF_NUM_SRC = 4;
  localparam int unsigned DEF_MAX_LEN = 100;
  localparam int unsigned DEF_DW      = 32;

  // Framer footer word; the framer appends it after the eng_last beat.
  localparam logic [DEF_DW-1:0] FOOTER = 32'hF00D_CAFE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD      = 2'd1,
    DROP     = 2'd2,
    WAIT_ENG = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  logic [IW-1:0] idx;

  // Search ptr+1, ptr+2, ... so the last winner has lowest priority.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/packet_ingress_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared framer,
// truncating packets longer than MAX_LEN beats.
module packet_ingress_arbiter
  import pkt_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned DW      = DEF_DW
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*DW-1:0]      src_data,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       eng_valid,
  output logic [DW-1:0]              eng_data,
  output logic                       eng_last,
  input  logic                       eng_done,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy,
  output logic                       len_err
);

  localparam int unsigned IW = $clog2(NUM_SRC);
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          eng_valid_q, eng_valid_d;
  logic          eng_last_q, eng_last_d;
  logic [DW-1:0] eng_data_q, eng_data_d;
  logic          len_err_q, len_err_d;

  logic [IW-1:0] winner;
  logic          any_req;
  logic          g_valid;
  logic          g_last;
  logic [DW-1:0] g_data;
  logic          cnt_at_max;

  rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_rr_pick (
    .req     (src_valid),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Granted-source mux.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IW'(i)) g_data = src_data[i*DW +: DW];
    end
  end

  assign g_valid    = src_valid[grant_q];
  assign g_last     = src_last[grant_q];
  assign cnt_at_max = (beat_cnt_q == CW'(MAX_LEN - 1));

  // Next-state and output-register inputs.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    eng_valid_d = 1'b0;
    eng_last_d  = 1'b0;
    eng_data_d  = eng_data_q;
    len_err_d   = 1'b0;
    src_ready   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = winner;
          beat_cnt_d = '0;
          state_d    = FWD;
        end
      end
      FWD: begin
        src_ready[grant_q] = 1'b1;
        if (g_valid) begin
          eng_valid_d = 1'b1;
          eng_data_d  = g_data;
          beat_cnt_d  = beat_cnt_q + CW'(1);
          eng_last_d  = g_last | cnt_at_max;
          if (g_last) begin
            state_d = WAIT_ENG;
          end else if (cnt_at_max) begin
            len_err_d = 1'b1;
            state_d   = DROP;
          end
        end
      end
      DROP: begin
        src_ready[grant_q] = 1'b1;
        if (g_valid && g_last) state_d = WAIT_ENG;
      end
      WAIT_ENG: begin
        if (eng_done) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IW'(NUM_SRC - 1);
      beat_cnt_q  <= '0;
      eng_valid_q <= 1'b0;
      eng_last_q  <= 1'b0;
      eng_data_q  <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      eng_valid_q <= eng_valid_d;
      eng_last_q  <= eng_last_d;
      eng_data_q  <= eng_data_d;
      len_err_q   <= len_err_d;
    end
  end

  assign eng_valid = eng_valid_q;
  assign eng_last  = eng_last_q;
  assign eng_data  = eng_data_q;
  assign len_err   = len_err_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);

endmodule
